// File: rtl/operand_stager_if.sv
`default_nettype none
// ============================================================================
// operand_stager_if -- upstream word stream, staged operands and mux handshake
// Revision: 1.0
// ============================================================================
interface operand_stager_if #(
  parameter int INPUT_LENGTH = 8
);
  logic                    in_valid;
  logic [INPUT_LENGTH-1:0] in_data;
  logic                    in_ready;
  logic [INPUT_LENGTH-1:0] a;
  logic [INPUT_LENGTH-1:0] b;
  logic [INPUT_LENGTH-1:0] c;
  logic [INPUT_LENGTH-1:0] d;
  logic [1:0]              sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, a, b, c, d, sel, out_valid
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, a, b, c, d, sel, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/operand_stager.sv
`default_nettype none
// ============================================================================
// operand_stager -- collects four operand words, then steps the mux select
// through them. OPERAND_STAGER_DOUBLE_BUF_EN adds a shadow bank for refill
// during presentation.
// Revision: 1.0
// ============================================================================
module operand_stager #(
  parameter int INPUT_LENGTH = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       flush,
  operand_stager_if.slave bus
);

  typedef enum logic [0:0] {
    S_FILL    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t                  state_q;
  logic [1:0]              fill_cnt_q;
  logic [1:0]              sel_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [INPUT_LENGTH-1:0] ops_q [4];

  logic in_hs;
  logic out_hs;

  assign in_hs  = bus.in_valid && in_ready_q;
  assign out_hs = out_valid_q && bus.out_ready;

`ifdef OPERAND_STAGER_DOUBLE_BUF_EN
  logic [INPUT_LENGTH-1:0] sh_q [4];
  logic [INPUT_LENGTH-1:0] sh_d [4];
  logic [2:0]              sh_cnt_q;
  logic [2:0]              sh_cnt_d;
  logic                    sh_wr;

  // Shadow contents including a word accepted this same cycle.
  always_comb begin
    sh_wr    = in_hs && (state_q == S_PRESENT);
    sh_cnt_d = sh_cnt_q + {2'b00, sh_wr};
    for (int i = 0; i < 4; i++) begin
      sh_d[i] = (sh_wr && (sh_cnt_q[1:0] == 2'(i))) ? bus.in_data : sh_q[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      fill_cnt_q  <= 2'd0;
      sel_q       <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) ops_q[i] <= '0;
`ifdef OPERAND_STAGER_DOUBLE_BUF_EN
      sh_cnt_q <= 3'd0;
      for (int i = 0; i < 4; i++) sh_q[i] <= '0;
`endif
    end else if (flush) begin
      state_q     <= S_FILL;
      fill_cnt_q  <= 2'd0;
      sel_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef OPERAND_STAGER_DOUBLE_BUF_EN
      sh_cnt_q <= 3'd0;
`endif
    end else begin
      unique case (state_q)
        S_FILL: begin
          in_ready_q <= 1'b1;
          if (in_hs) begin
            ops_q[fill_cnt_q] <= bus.in_data;
            fill_cnt_q        <= fill_cnt_q + 2'd1;
            if (fill_cnt_q == 2'd3) begin
              state_q     <= S_PRESENT;
              sel_q       <= 2'd0;
              out_valid_q <= 1'b1;
`ifdef OPERAND_STAGER_DOUBLE_BUF_EN
              in_ready_q  <= 1'b1;
`else
              in_ready_q  <= 1'b0;
`endif
            end
          end
        end

        S_PRESENT: begin
`ifdef OPERAND_STAGER_DOUBLE_BUF_EN
          if (sh_wr) sh_q[sh_cnt_q[1:0]] <= bus.in_data;
          sh_cnt_q   <= sh_cnt_d;
          in_ready_q <= (sh_cnt_d != 3'd4);
`else
          in_ready_q <= 1'b0;
`endif
          if (out_hs) begin
            if (sel_q == 2'd3) begin
              sel_q <= 2'd0;
`ifdef OPERAND_STAGER_DOUBLE_BUF_EN
              sh_cnt_q   <= 3'd0;
              in_ready_q <= 1'b1;
              if (sh_cnt_d == 3'd4) begin
                for (int i = 0; i < 4; i++) ops_q[i] <= sh_d[i];
              end else begin
                // Words already accepted into the shadow seed the next fill.
                for (int i = 0; i < 4; i++) begin
                  if (3'(i) < sh_cnt_d) ops_q[i] <= sh_d[i];
                end
                fill_cnt_q  <= sh_cnt_d[1:0];
                state_q     <= S_FILL;
                out_valid_q <= 1'b0;
              end
`else
              fill_cnt_q  <= 2'd0;
              state_q     <= S_FILL;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
`endif
            end else begin
              sel_q <= sel_q + 2'd1;
            end
          end
        end

        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.a         = ops_q[0];
  assign bus.b         = ops_q[1];
  assign bus.c         = ops_q[2];
  assign bus.d         = ops_q[3];

endmodule
`default_nettype wire

// File: tb/tb_operand_stager.sv
`default_nettype none
// ============================================================================
// tb_operand_stager -- directed self-checking bench for operand_stager
// Revision: 1.0
// ============================================================================
module tb_operand_stager;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  operand_stager_if #(.INPUT_LENGTH(8)) bus ();

  operand_stager #(.INPUT_LENGTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mux_z();
    case (bus.sel)
      2'd0:    return bus.a;
      2'd1:    return bus.b;
      2'd2:    return bus.c;
      default: return bus.d;
    endcase
  endfunction

  function automatic logic [7:0] op_at(input int i);
    case (i)
      0:       return bus.a;
      1:       return bus.b;
      2:       return bus.c;
      default: return bus.d;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", bus.sel); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (op_at(i) !== 8'h00) begin errors++; $display("FAIL reset_op%0d got %02h exp 00", i, op_at(i)); end
    end
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_held_in_ready got %0b exp 0", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_present();
    logic [7:0] exp [4];
    exp[0] = 8'h03; exp[1] = 8'hff; exp[2] = 8'h0f; exp[3] = 8'hee;
    bus.out_ready = 1'b1;
    feed4(8'h03, 8'hff, 8'h0f, 8'hee);
    for (int i = 0; i < 4; i++) begin
      checks++; if (op_at(i) !== exp[i]) begin errors++; $display("FAIL present_op%0d got %02h exp %02h", i, op_at(i), exp[i]); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL present_valid%0d got %0b exp 1", k, bus.out_valid); end
      checks++; if (bus.sel !== 2'(k)) begin errors++; $display("FAIL present_sel%0d got %0d exp %0d", k, bus.sel, k); end
      checks++; if (mux_z() !== exp[k]) begin errors++; $display("FAIL present_z%0d got %02h exp %02h", k, mux_z(), exp[k]); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL present_in_ready%0d got %0b exp 0", k, bus.in_ready); end
      step();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL present_end_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL present_end_in_ready got %0b exp 1", bus.in_ready); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL present_end_sel got %0d exp 0", bus.sel); end
  endtask

  task automatic test_stall();
    logic       pat     [6];
    logic [1:0] exp_sel [6];
    logic [7:0] exp     [4];
    int         hs;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 1;
    exp_sel[0] = 0; exp_sel[1] = 1; exp_sel[2] = 1; exp_sel[3] = 1; exp_sel[4] = 2; exp_sel[5] = 3;
    exp[0] = 8'h03; exp[1] = 8'hff; exp[2] = 8'h0f; exp[3] = 8'hee;
    hs = 0;
    bus.out_ready = 1'b0;
    feed4(8'h03, 8'hff, 8'h0f, 8'hee);
    // Upstream keeps offering a word that must not land while presenting.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = pat[i];
      checks++; if (bus.sel !== exp_sel[i]) begin errors++; $display("FAIL stall_sel%0d got %0d exp %0d", i, bus.sel, exp_sel[i]); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d got %0b exp 0", i, bus.in_ready); end
      if (bus.out_valid && bus.out_ready) hs++;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (hs !== 4) begin errors++; $display("FAIL stall_handshakes got %0d exp 4", hs); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_end_valid got %0b exp 0", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (op_at(i) !== exp[i]) begin errors++; $display("FAIL stall_op%0d got %02h exp %02h", i, op_at(i), exp[i]); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp_keep [4];
    logic [7:0] exp_new  [4];
    exp_keep[0] = 8'h00; exp_keep[1] = 8'h0f; exp_keep[2] = 8'h0f; exp_keep[3] = 8'hee;
    exp_new[0]  = 8'h00; exp_new[1]  = 8'h0f; exp_new[2]  = 8'hf0; exp_new[3]  = 8'h00;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h00; step();
    bus.in_valid = 1'b1; bus.in_data = 8'h0f; step();
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hf0;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b exp 0", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (op_at(i) !== exp_keep[i]) begin errors++; $display("FAIL flush_keep_op%0d got %02h exp %02h", i, op_at(i), exp_keep[i]); end
    end
    feed4(8'h00, 8'h0f, 8'hf0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checks++; if (op_at(i) !== exp_new[i]) begin errors++; $display("FAIL flush_refill_op%0d got %02h exp %02h", i, op_at(i), exp_new[i]); end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_refill_valid got %0b exp 1", bus.out_valid); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL flush_refill_sel got %0d exp 0", bus.sel); end

    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.sel !== 2'd1) begin errors++; $display("FAIL flushp_pre_sel got %0d exp 1", bus.sel); end
    flush = 1'b1;
    step();
    flush = 1'b0; bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flushp_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL flushp_sel got %0d exp 0", bus.sel); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flushp_in_ready got %0b exp 1", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (op_at(i) !== exp_new[i]) begin errors++; $display("FAIL flushp_op%0d got %02h exp %02h", i, op_at(i), exp_new[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    bus.out_ready = 1'b0;
    feed4(8'h03, 8'hff, 8'h0f, 8'hee);
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.sel !== 2'd2) begin errors++; $display("FAIL rstmid_pre_sel got %0d exp 2", bus.sel); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL rstmid_sel got %0d exp 0", bus.sel); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %0b exp 0", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (op_at(i) !== 8'h00) begin errors++; $display("FAIL rstmid_op%0d got %02h exp 00", i, op_at(i)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_in_ready got %0b exp 1", bus.in_ready); end
    feed4(8'h11, 8'h22, 8'h33, 8'h44);
    for (int i = 0; i < 4; i++) begin
      checks++; if (op_at(i) !== exp[i]) begin errors++; $display("FAIL rstmid_refill_op%0d got %02h exp %02h", i, op_at(i), exp[i]); end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_refill_valid got %0b exp 1", bus.out_valid); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_present();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
